mbc_multi: RTL and testbench
============================

Name: mbc_multi

Overview:
- Parametrised cartridge memory bank controller, the successor to the single-mode MBC5 mapper.
- Sits between the GameBoy cartridge bus (gb_*) and external ROM/RAM chip selects and upper address lines.
- MODE selects MBC1 or MBC5 register semantics; bank widths are parametrised.
- The GB write strobe is synchronised into gb_clk, and registers commit on its rising (write-end) edge.

Parameters:
MODE, 5, register map: 1 = MBC1, 5 = MBC5; any other value behaves as 5
ROM_BANK_BITS, 9, width of rom_a / rom_bank (2..9); upper computed bits truncated
RAM_BANK_BITS, 4, width of ram_a (1..4); upper computed bits truncated

Ports:
gb_clk  input  1  controller clock, all state on rising edge
gb_rst_n  input  1  asynchronous active-low reset
gb_a  input  4  GB address bits [15:12]
gb_d  input  8  GB data bus (write data)
gb_cs  input  1  GB external-RAM region select, active low
gb_wr  input  1  GB write strobe, active low, asynchronous to gb_clk
gb_rd  input  1  GB read strobe, active low
rom_a  output  ROM_BANK_BITS  ROM address bits [14+ROM_BANK_BITS-1:14]
ram_a  output  RAM_BANK_BITS  RAM address bits [13+RAM_BANK_BITS-1:13]
rom_cs  output  1  ROM chip select, active low
ram_cs  output  1  RAM chip select, active low
ddir  output  1  level-shifter direction: 1 = cart->GB, 0 = GB->cart
rom_bank  output  ROM_BANK_BITS  current effective switchable ROM bank (debug/LED)

Behaviour:
- Reset (async assert, sync deassert internally on gb_clk):
  - bank_lo = 1, bank_hi = 0, ram_en = 0, bank_mode = 0.
  - Sync flops wr_s1/wr_s2/wr_s3 = 1 (idle), capture regs = 0.
  - Outputs after reset: rom_bank = 1, ram_a = 0, ram_cs = 1.
- Write synchroniser:
  - wr_s1 <= gb_wr; wr_s2 <= wr_s1; wr_s3 <= wr_s2.
  - While wr_s2 == 0, cap_a <= gb_a and cap_d <= gb_d each cycle.
  - commit = wr_s2 & ~wr_s3.
  - A register update lands on the 3rd gb_clk rising edge after gb_wr rises and uses the last captured a/d.
  - Write pulses shorter than 2 gb_clk periods may be missed; this is permitted.
- Commit decode, MBC5 mode (cap_a):
  - 0x0/0x1: ram_en = (cap_d[3:0] == 4'hA).
  - 0x2: bank_lo[7:0] = cap_d.
  - 0x3: bank_lo[8] = cap_d[0].
  - 0x4/0x5: bank_hi[3:0] = cap_d[3:0].
  - 0x6/0x7: ignored.
  - Bank 0 is selectable for 0x4000-0x7FFF.
- Commit decode, MBC1 mode:
  - 0x0/0x1: ram_en as in MBC5.
  - 0x2/0x3: bank_lo[4:0] = cap_d[4:0], except that a written value of 0 is stored as 1 (so 0x20/0x40/0x60 resolve to 0x21/0x41/0x61 when bank_hi is set).
  - 0x4/0x5: bank_hi[1:0] = cap_d[1:0].
  - 0x6/0x7: bank_mode = cap_d[0].
- Effective banks, MBC5:
  - hi_bank = bank_lo[8:0]; lo_bank = 0; ram_bank = bank_hi[3:0].
- Effective banks, MBC1:
  - hi_bank = {bank_hi, bank_lo[4:0]}.
  - lo_bank = bank_mode ? {bank_hi, 5'b0} : 0.
  - ram_bank = bank_mode ? bank_hi : 0.
- Address outputs (combinational from gb_a and registers):
  - rom_a = truncated (gb_a[15:14] == 2'b00 ? lo_bank : hi_bank).
  - ram_a = truncated ram_bank.
  - rom_bank = truncated hi_bank.
- Chip selects and direction:
  - rom_cs = 0 iff gb_a[15] == 0 and not in reset.
  - ram_cs = 0 iff gb_a[15:13] == 3'b101 and gb_cs == 0 and ram_en == 1 and not in reset.
  - ddir = 1 iff gb_rd == 0 and gb_wr == 1 and (rom_cs == 0 or ram_cs == 0); otherwise 0.
  - gb_rd and gb_wr both low gives ddir = 0.
- Simultaneous or boundary cases:
  - Reset asserted mid-write: all state clears immediately; no commit fires after deassert because the sync flops reset to 1.
  - Writes to 0x8-0xF: ignored.
  - A bank number beyond the ROM_BANK_BITS width wraps by truncation.

Test Plan:
- Reset, then read 0x4xxx in MODE=5 -> rom_a = 9'h001, rom_cs = 0, ram_cs = 1, ddir = 1 while gb_rd = 0.
- MODE=5: write 0x2000 = 0xFF, then 0x3000 = 0x01 -> rom_bank = 9'h1FF exactly 3 gb_clk after the gb_wr rise; read 0x1xxx -> rom_a = 0.
- MODE=5: write 0x0000 = 0x0A, then 0x4000 = 0x0C, access 0xAxxx with gb_cs = 0 -> ram_cs = 0, ram_a = 4'hC; write 0x0000 = 0x00 -> ram_cs = 1.
- MODE=1: write 0x2000 = 0x00 -> rom_bank = 1; write 0x4000 = 0x02 and 0x2000 = 0x00 -> rom_bank = 0x41; write 0x6000 = 0x01 -> read 0x0xxx gives rom_a = 0x40, ram_a = 2.
- MODE=5, ROM_BANK_BITS = 5: write 0x2000 = 0x25 -> rom_bank = 5'h05.
- Assert gb_rst_n low while gb_wr is low mid-write to 0x2000 = 0x07, release after gb_wr rises -> rom_bank stays 1 and no commit occurs.

Source files
------------

// File: rtl/mbc_multi.sv
// Cartridge memory bank controller with selectable MBC1/MBC5 register semantics.
// The GB write strobe is synchronised into gb_clk, and registers commit on the write-end edge.
module mbc_multi #(
   parameter int          MODE          = 5,
   parameter int unsigned ROM_BANK_BITS = 9,
   parameter int unsigned RAM_BANK_BITS = 4
) (
   input  logic                     gb_clk,
   input  logic                     gb_rst_n,
   input  logic [3:0]               gb_a,
   input  logic [7:0]               gb_d,
   input  logic                     gb_cs,
   input  logic                     gb_wr,
   input  logic                     gb_rd,
   output logic [ROM_BANK_BITS-1:0] rom_a,
   output logic [RAM_BANK_BITS-1:0] ram_a,
   output logic                     rom_cs,
   output logic                     ram_cs,
   output logic                     ddir,
   output logic [ROM_BANK_BITS-1:0] rom_bank
);

   localparam bit IS_MBC1 = (MODE == 1);

   logic       rst_s1_q, rst_s2_q;
   logic       rst_n_int;
   logic       wr_s1_q, wr_s2_q, wr_s3_q;
   logic [3:0] cap_a_q;
   logic [7:0] cap_d_q;
   logic       commit;

   logic [8:0] bank_lo_q, bank_lo_d;
   logic [3:0] bank_hi_q, bank_hi_d;
   logic       ram_en_q, ram_en_d;
   logic       bank_mode_q, bank_mode_d;

   logic [8:0] hi_bank, lo_bank, rom_sel;
   logic [3:0] ram_bank;

   // Reset asserts asynchronously but releases only on a gb_clk edge.
   always_ff @(posedge gb_clk or negedge gb_rst_n) begin
      if (!gb_rst_n) begin
         rst_s1_q <= 1'b0;
         rst_s2_q <= 1'b0;
      end else begin
         rst_s1_q <= 1'b1;
         rst_s2_q <= rst_s1_q;
      end
   end

   assign rst_n_int = rst_s2_q;

   // Sync flops idle high so a reset mid-write cannot produce a spurious commit.
   always_ff @(posedge gb_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         wr_s1_q <= 1'b1;
         wr_s2_q <= 1'b1;
         wr_s3_q <= 1'b1;
         cap_a_q <= '0;
         cap_d_q <= '0;
      end else begin
         wr_s1_q <= gb_wr;
         wr_s2_q <= wr_s1_q;
         wr_s3_q <= wr_s2_q;
         if (!wr_s2_q) begin
            cap_a_q <= gb_a;
            cap_d_q <= gb_d;
         end
      end
   end

   assign commit = wr_s2_q & ~wr_s3_q;

   always_comb begin
      bank_lo_d   = bank_lo_q;
      bank_hi_d   = bank_hi_q;
      ram_en_d    = ram_en_q;
      bank_mode_d = bank_mode_q;
      if (commit) begin
         if (IS_MBC1) begin
            case (cap_a_q)
               4'h0, 4'h1: ram_en_d = (cap_d_q[3:0] == 4'hA);
               4'h2, 4'h3: bank_lo_d[4:0] = (cap_d_q[4:0] == 5'd0) ? 5'd1 : cap_d_q[4:0];
               4'h4, 4'h5: bank_hi_d[1:0] = cap_d_q[1:0];
               4'h6, 4'h7: bank_mode_d = cap_d_q[0];
               default: ;
            endcase
         end else begin
            case (cap_a_q)
               4'h0, 4'h1: ram_en_d = (cap_d_q[3:0] == 4'hA);
               4'h2:       bank_lo_d[7:0] = cap_d_q;
               4'h3:       bank_lo_d[8] = cap_d_q[0];
               4'h4, 4'h5: bank_hi_d = cap_d_q[3:0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge gb_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         bank_lo_q   <= 9'd1;
         bank_hi_q   <= '0;
         ram_en_q    <= 1'b0;
         bank_mode_q <= 1'b0;
      end else begin
         bank_lo_q   <= bank_lo_d;
         bank_hi_q   <= bank_hi_d;
         ram_en_q    <= ram_en_d;
         bank_mode_q <= bank_mode_d;
      end
   end

   always_comb begin
      if (IS_MBC1) begin
         hi_bank  = {2'b00, bank_hi_q[1:0], bank_lo_q[4:0]};
         lo_bank  = bank_mode_q ? {2'b00, bank_hi_q[1:0], 5'b00000} : 9'd0;
         ram_bank = bank_mode_q ? bank_hi_q : 4'd0;
      end else begin
         hi_bank  = bank_lo_q;
         lo_bank  = 9'd0;
         ram_bank = bank_hi_q;
      end
      rom_sel = (gb_a[3:2] == 2'b00) ? lo_bank : hi_bank;
   end

   assign rom_a    = rom_sel[ROM_BANK_BITS-1:0];
   assign rom_bank = hi_bank[ROM_BANK_BITS-1:0];
   assign ram_a    = ram_bank[RAM_BANK_BITS-1:0];

   assign rom_cs = ~(~gb_a[3] & rst_n_int);
   assign ram_cs = ~((gb_a[3:1] == 3'b101) & ~gb_cs & ram_en_q & rst_n_int);
   assign ddir   = ~gb_rd & gb_wr & (~rom_cs | ~ram_cs);

endmodule

// File: tb/tb_mbc_multi.sv
// Directed bench for mbc_multi: three instances (MBC5, MBC1, MBC5 with 5-bit ROM bank) on one shared bus.
module tb_mbc_multi;

   logic       gb_clk;
   logic       gb_rst_n;
   logic [3:0] gb_a;
   logic [7:0] gb_d;
   logic       gb_cs, gb_wr, gb_rd;

   logic [8:0] d5_rom_a, d5_rom_bank;
   logic [3:0] d5_ram_a;
   logic       d5_rom_cs, d5_ram_cs, d5_ddir;

   logic [8:0] d1_rom_a, d1_rom_bank;
   logic [3:0] d1_ram_a;
   logic       d1_rom_cs, d1_ram_cs, d1_ddir;

   logic [4:0] dn_rom_a, dn_rom_bank;
   logic [3:0] dn_ram_a;
   logic       dn_rom_cs, dn_ram_cs, dn_ddir;

   int n_chk  = 0;
   int n_fail = 0;

   mbc_multi #(.MODE(5)) u_d5 (
      .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .gb_a(gb_a), .gb_d(gb_d),
      .gb_cs(gb_cs), .gb_wr(gb_wr), .gb_rd(gb_rd),
      .rom_a(d5_rom_a), .ram_a(d5_ram_a), .rom_cs(d5_rom_cs),
      .ram_cs(d5_ram_cs), .ddir(d5_ddir), .rom_bank(d5_rom_bank)
   );

   mbc_multi #(.MODE(1)) u_d1 (
      .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .gb_a(gb_a), .gb_d(gb_d),
      .gb_cs(gb_cs), .gb_wr(gb_wr), .gb_rd(gb_rd),
      .rom_a(d1_rom_a), .ram_a(d1_ram_a), .rom_cs(d1_rom_cs),
      .ram_cs(d1_ram_cs), .ddir(d1_ddir), .rom_bank(d1_rom_bank)
   );

   mbc_multi #(.MODE(5), .ROM_BANK_BITS(5)) u_dn (
      .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .gb_a(gb_a), .gb_d(gb_d),
      .gb_cs(gb_cs), .gb_wr(gb_wr), .gb_rd(gb_rd),
      .rom_a(dn_rom_a), .ram_a(dn_ram_a), .rom_cs(dn_rom_cs),
      .ram_cs(dn_ram_cs), .ddir(dn_ddir), .rom_bank(dn_rom_bank)
   );

   initial gb_clk = 1'b0;
   always #5 gb_clk = ~gb_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // gb_wr held low for 3 cycles, rises mid-cycle; returns 1 time unit after the 3rd edge.
   task automatic gb_write(input logic [3:0] a, input logic [7:0] d);
      @(negedge gb_clk);
      gb_a  = a;
      gb_d  = d;
      gb_wr = 1'b0;
      repeat (3) @(negedge gb_clk);
      gb_wr = 1'b1;
      repeat (3) @(posedge gb_clk);
      #1;
   endtask

   initial begin
      gb_rst_n = 1'b0;
      gb_a = 4'h0; gb_d = 8'h00;
      gb_cs = 1'b1; gb_wr = 1'b1; gb_rd = 1'b1;
      repeat (2) @(negedge gb_clk);

      chk("rst_rom_cs", {31'd0, d5_rom_cs}, 32'd1);
      chk("rst_rom_bank", {23'd0, d5_rom_bank}, 32'h001);
      chk("rst_ram_a", {28'd0, d5_ram_a}, 32'h0);
      chk("rst_ram_cs", {31'd0, d5_ram_cs}, 32'd1);

      gb_rst_n = 1'b1;
      repeat (4) @(negedge gb_clk);

      gb_a = 4'h4; gb_rd = 1'b0;
      #1;
      chk("rd4_rom_a", {23'd0, d5_rom_a}, 32'h001);
      chk("rd4_rom_cs", {31'd0, d5_rom_cs}, 32'd0);
      chk("rd4_ram_cs", {31'd0, d5_ram_cs}, 32'd1);
      chk("rd4_ddir", {31'd0, d5_ddir}, 32'd1);
      chk("rd4_m1_rom_a", {23'd0, d1_rom_a}, 32'h001);
      gb_wr = 1'b0;
      #1;
      chk("rdwr_ddir", {31'd0, d5_ddir}, 32'd0);
      gb_wr = 1'b1; gb_rd = 1'b1;
      #1;
      chk("idle_ddir", {31'd0, d5_ddir}, 32'd0);

      gb_write(4'h2, 8'hFF);
      chk("m5_lo_ff", {23'd0, d5_rom_bank}, 32'h0FF);

      // exact commit latency on the 0x3000 write
      @(negedge gb_clk);
      gb_a = 4'h3; gb_d = 8'h01; gb_wr = 1'b0;
      repeat (3) @(negedge gb_clk);
      gb_wr = 1'b1;
      repeat (2) @(posedge gb_clk);
      #1;
      chk("m5_hi_before3", {23'd0, d5_rom_bank}, 32'h0FF);
      @(posedge gb_clk);
      #1;
      chk("m5_hi_at3", {23'd0, d5_rom_bank}, 32'h1FF);
      chk("rb5_trunc_1ff", {27'd0, dn_rom_bank}, 32'h1F);
      chk("m1_lo_1", {23'd0, d1_rom_bank}, 32'h001);

      gb_a = 4'h1; gb_rd = 1'b0;
      #1;
      chk("rd1_rom_a", {23'd0, d5_rom_a}, 32'h000);
      chk("rd1_rom_cs", {31'd0, d5_rom_cs}, 32'd0);
      gb_a = 4'h5;
      #1;
      chk("rd5_rom_a", {23'd0, d5_rom_a}, 32'h1FF);
      gb_rd = 1'b1;

      gb_write(4'h0, 8'h0A);
      gb_write(4'h4, 8'h0C);
      gb_a = 4'hA; gb_cs = 1'b0; gb_rd = 1'b0;
      #1;
      chk("ram_cs_en", {31'd0, d5_ram_cs}, 32'd0);
      chk("ram_a_c", {28'd0, d5_ram_a}, 32'hC);
      chk("ram_ddir", {31'd0, d5_ddir}, 32'd1);
      chk("m1_ram_a_mode0", {28'd0, d1_ram_a}, 32'h0);
      gb_a = 4'hC;
      #1;
      chk("ram_cs_c000", {31'd0, d5_ram_cs}, 32'd1);
      gb_rd = 1'b1; gb_cs = 1'b1;

      gb_write(4'hA, 8'h55);
      chk("wr_a_ignored", {23'd0, d5_rom_bank}, 32'h1FF);
      chk("wr_a_ram_a", {28'd0, d5_ram_a}, 32'hC);

      gb_write(4'h0, 8'h00);
      gb_a = 4'hA; gb_cs = 1'b0;
      #1;
      chk("ram_cs_dis", {31'd0, d5_ram_cs}, 32'd1);
      gb_cs = 1'b1;

      gb_write(4'h2, 8'h00);
      chk("m1_zero_as_1", {23'd0, d1_rom_bank}, 32'h001);
      chk("m5_bank_100", {23'd0, d5_rom_bank}, 32'h100);
      gb_write(4'h4, 8'h02);
      gb_write(4'h2, 8'h00);
      chk("m1_bank_41", {23'd0, d1_rom_bank}, 32'h041);
      gb_write(4'h6, 8'h01);
      gb_a = 4'h0;
      #1;
      chk("m1_lo_40", {23'd0, d1_rom_a}, 32'h040);
      chk("m1_ram_a_2", {28'd0, d1_ram_a}, 32'h2);
      chk("m5_lo_0", {23'd0, d5_rom_a}, 32'h000);

      gb_write(4'h3, 8'h00);
      gb_write(4'h2, 8'h25);
      chk("rb5_trunc_25", {27'd0, dn_rom_bank}, 32'h05);
      chk("m5_bank_25", {23'd0, d5_rom_bank}, 32'h025);
      chk("m1_bank_45", {23'd0, d1_rom_bank}, 32'h045);

      // reset asserted while gb_wr low, released after gb_wr rises
      @(negedge gb_clk);
      gb_a = 4'h2; gb_d = 8'h07; gb_wr = 1'b0;
      repeat (3) @(negedge gb_clk);
      gb_rst_n = 1'b0;
      #1;
      chk("rstmid_immediate", {23'd0, d5_rom_bank}, 32'h001);
      @(negedge gb_clk);
      gb_wr = 1'b1;
      repeat (2) @(negedge gb_clk);
      gb_rst_n = 1'b1;
      repeat (6) @(negedge gb_clk);
      chk("rstmid_m5", {23'd0, d5_rom_bank}, 32'h001);
      chk("rstmid_m1", {23'd0, d1_rom_bank}, 32'h001);
      chk("rstmid_rb5", {27'd0, dn_rom_bank}, 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
